// File: rtl/mem_access_controller.sv
// Load/store sequencer between the datapath memory stage and a req/ack word memory.
// Word and signed-byte accesses; byte stores go through a read-modify-write pair.
module mem_access_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        i_req,
    input  logic        i_we,
    input  logic        i_byte,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_WR     = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

    logic [2:0]  state;
    logic        byte_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merged_q;
    logic [31:0] wait_cnt;

    logic [4:0]  shift;
    logic [7:0]  lane;
    logic [31:0] merged;
    logic        busy;
    logic        timeout;

    assign shift  = {addr_q[1:0], 3'b000};
    assign lane   = 8'(m_rdata >> shift);
    assign merged = (m_rdata & ~(32'h0000_00FF << shift)) | ({24'h0, wdata_q[7:0]} << shift);

    assign busy = (state == S_RD) || (state == S_WR) || (state == S_RMW_RD) || (state == S_RMW_WR);

    // An ack arriving on the last allowed cycle still completes the access.
    assign timeout = (TO_LIMIT != 32'd0) && !m_ack && (wait_cnt == TO_LIMIT - 32'd1);

    assign o_stall = busy || ((state == S_IDLE) && i_req);
    assign o_done  = (state == S_DONE) || (state == S_ERR);
    assign o_err   = (state == S_ERR);

    assign m_req   = busy;
    assign m_we    = (state == S_WR) || (state == S_RMW_WR);
    assign m_addr  = busy ? {addr_q[31:2], 2'b00} : 32'h0;
    assign m_wdata = (state == S_WR) ? wdata_q : (state == S_RMW_WR) ? merged_q : 32'h0;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state    <= S_IDLE;
            byte_q   <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            merged_q <= 32'h0;
            wait_cnt <= 32'h0;
            o_rdata  <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    wait_cnt <= 32'h0;
                    if (i_req) begin
                        byte_q  <= i_byte;
                        addr_q  <= i_addr;
                        wdata_q <= i_wdata;
                        if (!i_byte && (i_addr[1:0] != 2'b00)) begin
                            state   <= S_ERR;
                            o_rdata <= 32'h0;
                        end else if (!i_we) begin
                            state <= S_RD;
                        end else if (!i_byte) begin
                            state <= S_WR;
                        end else begin
                            state <= S_RMW_RD;
                        end
                    end
                end
                S_RD, S_WR, S_RMW_RD, S_RMW_WR: begin
                    if (m_ack) begin
                        wait_cnt <= 32'h0;
                        case (state)
                            S_RD: begin
                                state   <= S_DONE;
                                o_rdata <= byte_q ? {{24{lane[7]}}, lane} : m_rdata;
                            end
                            S_RMW_RD: begin
                                state    <= S_RMW_WR;
                                merged_q <= merged;
                            end
                            default: state <= S_DONE;
                        endcase
                    end else if (timeout) begin
                        wait_cnt <= 32'h0;
                        state    <= S_ERR;
                        o_rdata  <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
